gpio_input_conditioner: RTL and testbench

//  Parametrised conditioning front end for the board's raw player controls: N_BTN GPIO push-buttons
//  and N_SW slide switches. Each input is synchronised into the clock domain, debounced, and

---
 rtl/galaga_io_pkg.sv | 18 +
 rtl/input_debounce_ch.sv | 65 ++++++
 rtl/gpio_input_conditioner.sv | 122 ++++++++++++
 tb/tb_gpio_input_conditioner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/galaga_io_pkg.sv
// Shared types and width helpers for the player-control input conditioner.
package galaga_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD_WAIT,
    HELD_RPT
  } btn_state_t;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned DB_W  = cnt_w(250_000 - 1);
  localparam int unsigned RPT_W = cnt_w(25_000_000);

endpackage

// File: rtl/input_debounce_ch.sv
// One input channel: synchroniser chain, debounce counter and registered level/edge outputs.
module input_debounce_ch
  import galaga_io_pkg::*;
#(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned DbCycles   = 8,
  parameter bit          RawIdle    = 1'b0,
  parameter bit          Invert     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned DbW = cnt_w(DbCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic [DbW-1:0]        cnt_q, cnt_d;
  logic                  stable_q, stable_d;
  logic                  level_q, rise_q, fall_q;
  logic                  synced;

  assign synced = sync_q[SyncStages-1] ^ Invert;

  // Any sample that agrees with the stable level restarts the window.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (synced != stable_q) begin
      if (cnt_q == DbW'(DbCycles - 1)) begin
        stable_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= {SyncStages{RawIdle}};
      cnt_q    <= '0;
      stable_q <= 1'b0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SyncStages-2:0], raw_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      level_q  <= stable_q;
      rise_q   <= stable_q & ~level_q;
      fall_q   <= ~stable_q & level_q;
    end
  end

  assign stable_o = stable_q;
  assign level_o  = level_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Conditions raw buttons and switches: sync, debounce, polarity, edge pulses and hold auto-repeat.
module gpio_input_conditioner
  import galaga_io_pkg::*;
#(
  parameter int unsigned N_BTN          = 4,
  parameter int unsigned N_SW           = 10,
  parameter bit          BTN_ACTIVE_LOW = 1'b1,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DB_CYCLES      = 250_000,
  parameter int unsigned REPEAT_DELAY   = 25_000_000,
  parameter int unsigned REPEAT_PERIOD  = 5_000_000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [N_BTN-1:0] gpio_btn,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_SW-1:0]  sw_level
);

  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = cnt_w(RptMax);

  logic [N_BTN-1:0] btn_stable;
  logic [N_SW-1:0]  unused_sw_stable, unused_sw_rise, unused_sw_fall;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    input_debounce_ch #(
      .SyncStages (SYNC_STAGES),
      .DbCycles   (DB_CYCLES),
      .RawIdle    (1'b0),
      .Invert     (1'b0)
    ) u_db (
      .clk_i    (CLOCK_50),
      .rst_i    (reset),
      .raw_i    (sw_raw[i]),
      .stable_o (unused_sw_stable[i]),
      .level_o  (sw_level[i]),
      .rise_o   (unused_sw_rise[i]),
      .fall_o   (unused_sw_fall[i])
    );
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_state_t      state_q, state_d;
    logic [RptW-1:0] cnt_q, cnt_d;
    logic            fire, rpt_q;

    input_debounce_ch #(
      .SyncStages (SYNC_STAGES),
      .DbCycles   (DB_CYCLES),
      .RawIdle    (BTN_ACTIVE_LOW),
      .Invert     (BTN_ACTIVE_LOW)
    ) u_db (
      .clk_i    (CLOCK_50),
      .rst_i    (reset),
      .raw_i    (gpio_btn[i]),
      .stable_o (btn_stable[i]),
      .level_o  (btn_level[i]),
      .rise_o   (btn_press[i]),
      .fall_o   (btn_release[i])
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        rpt_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rpt_q   <= fire;
      end
    end

    // Tracks the pre-register stable level, one cycle ahead of btn_level, so the FSM
    // leaves the held states before a repeat could land in the release cycle.
    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
        IDLE: begin
          if (btn_stable[i]) state_d = HELD_WAIT;
        end
        HELD_WAIT: begin
          if (!btn_stable[i]) begin
            state_d = IDLE;
          end else if (fire) begin
            state_d = HELD_RPT;
          end else if (REPEAT_DELAY != 0) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD_RPT: begin
          if (!btn_stable[i]) begin
            state_d = IDLE;
          end else if (!fire) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      fire = 1'b0;
      if (btn_stable[i]) begin
        unique case (state_q)
          HELD_WAIT: fire = (REPEAT_DELAY != 0) && (cnt_q == RptW'(REPEAT_DELAY - 1));
          HELD_RPT:  fire = (cnt_q == RptW'(REPEAT_PERIOD - 1));
          default:   fire = 1'b0;
        endcase
      end
    end

    assign btn_repeat[i] = rpt_q;
  end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner: vector table plus multi-cycle hand sequences.
module tb_gpio_input_conditioner;

  logic       CLOCK_50;
  logic       reset;
  logic [3:0] gpio_btn;
  logic [1:0] sw_raw;
  logic [3:0] btn_level, btn_press, btn_release, btn_repeat;
  logic [1:0] sw_level;

  int n_tests;
  int n_fail;
  int press_cnt, rel_cnt, rpt_cnt, press_at;

  typedef struct {
    logic [3:0] btn;
    logic [1:0] sw;
    int         cyc;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
    logic [1:0] swl;
  } vec_t;

  vec_t vecs[10];

  gpio_input_conditioner #(
    .N_BTN          (4),
    .N_SW           (2),
    .BTN_ACTIVE_LOW (1'b1),
    .SYNC_STAGES    (2),
    .DB_CYCLES      (8),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .gpio_btn    (gpio_btn),
    .sw_raw      (sw_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat),
    .sw_level    (sw_level)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs and samples both land 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Table: each row applied from the state left by the previous one.
    vecs[0] = '{4'hF, 2'b01, 10, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00};
    vecs[1] = '{4'hF, 2'b01,  1, 4'h0, 4'h0, 4'h0, 4'h0, 2'b01};
    vecs[2] = '{4'hE, 2'b01, 10, 4'h0, 4'h0, 4'h0, 4'h0, 2'b01};
    vecs[3] = '{4'hE, 2'b01,  1, 4'h1, 4'h1, 4'h0, 4'h0, 2'b01};
    vecs[4] = '{4'hE, 2'b01,  1, 4'h1, 4'h0, 4'h0, 4'h0, 2'b01};
    vecs[5] = '{4'hF, 2'b11, 10, 4'h1, 4'h0, 4'h0, 4'h0, 2'b01};
    vecs[6] = '{4'hF, 2'b11,  1, 4'h0, 4'h0, 4'h1, 4'h0, 2'b11};
    vecs[7] = '{4'hF, 2'b10, 11, 4'h0, 4'h0, 4'h0, 4'h0, 2'b10};
    vecs[8] = '{4'hF, 2'b00, 11, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00};
    vecs[9] = '{4'hF, 2'b00,  5, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00};

    // 1. Reset with buttons at their inactive (high) level.
    reset    = 1'b1;
    gpio_btn = 4'hF;
    sw_raw   = 2'b00;
    step(3);
    check("rst level", 32'(btn_level), 32'h0);
    check("rst press", 32'(btn_press), 32'h0);
    check("rst release", 32'(btn_release), 32'h0);
    check("rst repeat", 32'(btn_repeat), 32'h0);
    check("rst sw", 32'(sw_level), 32'h0);
    reset = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      step(1);
      check($sformatf("idle c%0d", c),
            32'({btn_level, btn_press, btn_release, btn_repeat, sw_level}), 32'h0);
    end

    // 2. Table-driven press/release and switch levels.
    for (int i = 0; i < 10; i++) begin
      gpio_btn = vecs[i].btn;
      sw_raw   = vecs[i].sw;
      step(vecs[i].cyc);
      check($sformatf("vec%0d level", i), 32'(btn_level), 32'(vecs[i].lvl));
      check($sformatf("vec%0d press", i), 32'(btn_press), 32'(vecs[i].prs));
      check($sformatf("vec%0d release", i), 32'(btn_release), 32'(vecs[i].rel));
      check($sformatf("vec%0d repeat", i), 32'(btn_repeat), 32'(vecs[i].rpt));
      check($sformatf("vec%0d sw", i), 32'(sw_level), 32'(vecs[i].swl));
    end

    // 3. Bouncing ch1: one press, 10 edges after the final transition.
    press_cnt = 0;
    rel_cnt   = 0;
    rpt_cnt   = 0;
    press_at  = -1;
    for (int c = 0; c <= 38; c++) begin
      gpio_btn[1] = (c < 24) ? (((c / 3) % 2) != 0) : 1'b0;
      step(1);
      if (btn_press[1]) begin
        press_cnt++;
        press_at = c;
      end
      if (btn_release[1]) rel_cnt++;
      if (btn_repeat[1]) rpt_cnt++;
    end
    check("bounce press count", 32'(press_cnt), 32'd1);
    check("bounce press cycle", 32'(press_at), 32'd34);
    check("bounce release count", 32'(rel_cnt), 32'd0);
    check("bounce level", 32'(btn_level[1]), 32'd1);
    gpio_btn[1] = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step(1);
      if (btn_repeat[1]) rpt_cnt++;
      if (c == 10) check("bounce rel early", 32'(btn_release), 32'h0);
      if (c == 11) check("bounce rel", 32'(btn_release), 32'h2);
    end
    check("bounce repeat count", 32'(rpt_cnt), 32'd0);

    // 4. Hold ch2: press at c=11, repeats at +20 then every 5, release applied at c=71.
    gpio_btn[2] = 1'b0;
    for (int c = 1; c <= 90; c++) begin
      logic e_lvl, e_prs, e_rel, e_rpt;
      step(1);
      e_lvl = (c >= 11) && (c < 82);
      e_prs = (c == 11);
      e_rel = (c == 82);
      e_rpt = (c >= 31) && (c <= 81) && (((c - 31) % 5) == 0);
      check($sformatf("hold c%0d", c),
            32'({btn_level[2], btn_press[2], btn_release[2], btn_repeat[2]}),
            32'({e_lvl, e_prs, e_rel, e_rpt}));
      if (c == 71) gpio_btn[2] = 1'b1;
    end

    // 5. Press ch0 and release ch3 on the same input edge.
    gpio_btn[3] = 1'b0;
    step(11);
    check("ch3 press", 32'(btn_press), 32'h8);
    step(2);
    gpio_btn = 4'hE;
    step(10);
    check("same-cycle early", 32'({btn_press, btn_release}), 32'h0);
    step(1);
    check("same-cycle press", 32'(btn_press), 32'h1);
    check("same-cycle release", 32'(btn_release), 32'h8);
    check("same-cycle level", 32'(btn_level), 32'h1);
    check("same-cycle repeat", 32'(btn_repeat), 32'h0);
    gpio_btn = 4'hF;
    step(11);
    check("ch0 release", 32'(btn_release), 32'h1);
    check("ch0 level off", 32'(btn_level), 32'h0);
    step(3);

    // 6. Reset mid-debounce on ch1, then a fresh full latency.
    gpio_btn[1] = 1'b0;
    step(5);
    reset = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step(1);
      check($sformatf("mid-rst c%0d", c),
            32'({btn_level, btn_press, btn_release, btn_repeat}), 32'h0);
    end
    reset = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      step(1);
      check($sformatf("post-rst c%0d", c), 32'({btn_level, btn_press}),
            (c == 11) ? 32'h22 : 32'h0);
    end
    gpio_btn[1] = 1'b1;
    step(11);
    check("post-rst release", 32'(btn_release), 32'h2);
    step(2);
    check("final idle", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
